// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared CPU constants and the stage occupancy-state encoding
package pipe_stage_reg_pkg;
    localparam logic [31:0] CPU_PC_DEFAULT = 32'h0000_3000;
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;
endpackage

// File: rtl/pipe_stage_entry.sv
// pipe_stage_entry: one payload register with synchronous clear and load
module pipe_stage_entry #(
    parameter int           W       = 1,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;
    // clear wins over load so reset/flush always land on the clear value
    always_ff @(posedge clk) begin
        if (i_clr) r_q <= CLR_VAL;
        else if (i_load) r_q <= i_d;
    end
    assign o_q = r_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register, optional two-entry skid buffer
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int               PC_W       = 32,
    parameter int               INSTR_W    = 32,
    parameter int               A3_W       = 5,
    parameter int               WD_W       = 32,
    parameter logic [PC_W-1:0]  PC_DEFAULT = PC_W'(CPU_PC_DEFAULT),
    parameter int               SKID       = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [A3_W-1:0]    in_a3,
    input  logic [WD_W-1:0]    in_wd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [A3_W-1:0]    out_a3,
    output logic [WD_W-1:0]    out_wd,
    output logic [1:0]         occupancy
);
    localparam int            BW     = PC_W + INSTR_W + A3_W + WD_W;
    localparam logic [BW-1:0] BUBBLE = {PC_DEFAULT, {(BW - PC_W){1'b0}}};

    stage_state_t  r_state;
    stage_state_t  w_state_nx;
    logic          w_acc;
    logic          w_con;
    logic          w_main_ld;
    logic          w_main_clr;
    logic          w_from_skid;
    logic          w_skid_ld;
    logic          w_skid_clr;
    logic [BW-1:0] w_in_b;
    logic [BW-1:0] w_main_d;
    logic [BW-1:0] w_main_q;
    logic [BW-1:0] w_skid_q;

    // in skid mode in_ready decodes only the state flop, never out_ready
    assign in_ready  = (SKID != 0) ? (reset && r_state != ST_TWO) : (reset && (!out_valid || out_ready));
    assign out_valid = r_state != ST_EMPTY;
    assign occupancy = r_state;
    assign w_acc     = in_valid && in_ready;
    assign w_con     = out_valid && out_ready;
    assign w_in_b    = {in_pc, in_instr, in_a3, in_wd};
    assign w_main_d  = w_from_skid ? w_skid_q : w_in_b;
    assign {out_pc, out_instr, out_a3, out_wd} = w_main_q;

    // occupancy state register
    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_EMPTY;
        else r_state <= w_state_nx;
    end

    // next state and entry controls; main is cleared whenever it empties so idle outputs read as a nop
    always_comb begin
        w_state_nx  = r_state;
        w_main_ld   = 1'b0;
        w_main_clr  = 1'b0;
        w_from_skid = 1'b0;
        w_skid_ld   = 1'b0;
        w_skid_clr  = 1'b0;
        if (!reset || flush) begin
            w_state_nx = ST_EMPTY;
            w_main_clr = 1'b1;
            w_skid_clr = 1'b1;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        w_state_nx = ST_ONE;
                        w_main_ld  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_acc && w_con) begin
                        w_main_ld = 1'b1;
                    end else if (w_acc) begin
                        w_state_nx = ST_TWO;
                        w_skid_ld  = 1'b1;
                    end else if (w_con) begin
                        w_state_nx = ST_EMPTY;
                        w_main_clr = 1'b1;
                    end
                end
                ST_TWO: begin
                    if (w_con) begin
                        w_state_nx  = ST_ONE;
                        w_main_ld   = 1'b1;
                        w_from_skid = 1'b1;
                        w_skid_clr  = 1'b1;
                    end
                end
                default: w_state_nx = ST_EMPTY;
            endcase
        end
    end

    pipe_stage_entry #(.W(BW), .CLR_VAL(BUBBLE)) u_main (
        .clk    (clk),
        .i_clr  (w_main_clr),
        .i_load (w_main_ld),
        .i_d    (w_main_d),
        .o_q    (w_main_q)
    );

    if (SKID != 0) begin : g_skid
        pipe_stage_entry #(.W(BW), .CLR_VAL('0)) u_skid (
            .clk    (clk),
            .i_clr  (w_skid_clr),
            .i_load (w_skid_ld),
            .i_d    (w_in_b),
            .o_q    (w_skid_q)
        );
    end else begin : g_noskid
        assign w_skid_q = '0;
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of both buffering modes plus a scoreboarded random run
module tb_pipe_stage_reg;
    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_valid0, out_ready, out_ready0;
    logic [31:0] in_pc, in_instr, in_wd;
    logic [4:0]  in_a3;
    logic        in_ready1, out_valid1, in_ready0, out_valid0;
    logic [31:0] out_pc1, out_instr1, out_wd1, out_pc0, out_instr0, out_wd0;
    logic [4:0]  out_a3_1, out_a3_0;
    logic [1:0]  occ1, occ0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] q[$];
    logic [31:0] next_pc;
    logic        acc, con;

    always #5 clk = ~clk;

    pipe_stage_reg #(.SKID(1)) dut1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .in_pc(in_pc), .in_instr(in_instr), .in_a3(in_a3), .in_wd(in_wd),
        .out_valid(out_valid1), .out_ready(out_ready), .out_pc(out_pc1), .out_instr(out_instr1),
        .out_a3(out_a3_1), .out_wd(out_wd1), .occupancy(occ1)
    );

    pipe_stage_reg #(.SKID(0)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_pc(in_pc), .in_instr(in_instr), .in_a3(in_a3), .in_wd(in_wd),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_pc(out_pc0), .out_instr(out_instr0),
        .out_a3(out_a3_0), .out_wd(out_wd0), .occupancy(occ0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc);
        in_pc    = pc;
        in_instr = pc + 32'h1000_0000;
        in_a3    = pc[6:2];
        in_wd    = ~pc;
    endtask

    task automatic chk1(input string tag, input logic v, input logic [31:0] pc, input logic [1:0] oc);
        chk({tag, "_valid"}, 32'(out_valid1), 32'(v));
        chk({tag, "_pc"}, out_pc1, v ? pc : 32'h0000_3000);
        chk({tag, "_instr"}, out_instr1, v ? pc + 32'h1000_0000 : 32'h0);
        chk({tag, "_wd"}, out_wd1, v ? ~pc : 32'h0);
        chk({tag, "_a3"}, 32'(out_a3_1), v ? 32'(pc[6:2]) : 32'h0);
        chk({tag, "_occ"}, 32'(occ1), 32'(oc));
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_valid0 = 1'b0;
        out_ready = 1'b0; out_ready0 = 1'b0;
        drive(32'h0);
        tick();
        tick();
        chk1("rst", 1'b0, 32'h0, 2'd0);
        chk("rst_rdy1", 32'(in_ready1), 32'h0);
        chk("rst_rdy0", 32'(in_ready0), 32'h0);
        chk("rst_pc0", out_pc0, 32'h0000_3000);
        reset = 1'b1;
        #1;
        chk("rel_rdy1", 32'(in_ready1), 32'h1);
        chk("rel_rdy0", 32'(in_ready0), 32'h1);
        // fill the skid buffer with downstream stalled
        in_valid = 1'b1;
        drive(32'h3000);
        tick();
        chk1("push1", 1'b1, 32'h3000, 2'd1);
        chk("push1_rdy", 32'(in_ready1), 32'h1);
        drive(32'h3004);
        tick();
        chk1("push2", 1'b1, 32'h3000, 2'd2);
        chk("push2_rdy", 32'(in_ready1), 32'h0);
        drive(32'h3008);
        tick();
        chk1("full_hold", 1'b1, 32'h3000, 2'd2);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drive(32'hDEAD_BEEF);
        tick();
        chk1("drain1", 1'b1, 32'h3004, 2'd1);
        chk("drain1_rdy", 32'(in_ready1), 32'h1);
        tick();
        chk1("drain2", 1'b0, 32'h0, 2'd0);
        // flush at occupancy 2 with a pending input
        out_ready = 1'b0;
        in_valid = 1'b1;
        drive(32'h3000);
        tick();
        drive(32'h3004);
        tick();
        chk1("pre_flush", 1'b1, 32'h3000, 2'd2);
        flush = 1'b1;
        drive(32'h3008);
        tick();
        chk1("flush2", 1'b0, 32'h0, 2'd0);
        chk("flush2_rdy", 32'(in_ready1), 32'h1);
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        chk1("flush2_after", 1'b0, 32'h0, 2'd0);
        // flush while the stage is accepting a bundle discards it
        in_valid = 1'b1;
        drive(32'h3010);
        tick();
        flush = 1'b1;
        drive(32'h3014);
        tick();
        chk1("flush1", 1'b0, 32'h0, 2'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        chk1("flush1_after", 1'b0, 32'h0, 2'd0);
        // reset beats flush, including from state TWO
        in_valid = 1'b1;
        drive(32'h3020);
        tick();
        drive(32'h3024);
        tick();
        chk("pre_rst_occ", 32'(occ1), 32'h2);
        flush = 1'b1;
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        chk1("rst_flush", 1'b0, 32'h0, 2'd0);
        chk("rst_flush_rdy1", 32'(in_ready1), 32'h0);
        chk("rst_flush_rdy0", 32'(in_ready0), 32'h0);
        flush = 1'b0;
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk1("rst_flush_after", 1'b0, 32'h0, 2'd0);
        // streaming through both modes
        in_valid = 1'b1;
        in_valid0 = 1'b1;
        out_ready0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(32'h3000 + 32'(4 * i));
            tick();
            chk1($sformatf("strm1_%0d", i), 1'b1, 32'h3000 + 32'(4 * i), 2'd1);
            chk($sformatf("strm0_pc_%0d", i), out_pc0, 32'h3000 + 32'(4 * i));
            chk($sformatf("strm0_wd_%0d", i), out_wd0, ~(32'h3000 + 32'(4 * i)));
            chk($sformatf("strm0_occ_%0d", i), 32'(occ0), 32'h1);
            chk($sformatf("strm0_v_%0d", i), 32'(out_valid0), 32'h1);
        end
        in_valid = 1'b0;
        in_valid0 = 1'b0;
        tick();
        chk1("strm_end", 1'b0, 32'h0, 2'd0);
        chk("strm_end_v0", 32'(out_valid0), 32'h0);
        chk("strm_end_pc0", out_pc0, 32'h0000_3000);
        // single-register mode: in_ready follows out_ready combinationally when full
        in_valid0 = 1'b1;
        out_ready0 = 1'b0;
        drive(32'h3040);
        tick();
        in_valid0 = 1'b0;
        drive(32'h3044);
        #1;
        chk("s0_full_rdy", 32'(in_ready0), 32'h0);
        chk("s0_full_occ", 32'(occ0), 32'h1);
        out_ready0 = 1'b1;
        #1;
        chk("s0_comb_rdy", 32'(in_ready0), 32'h1);
        tick();
        chk("s0_drain_v", 32'(out_valid0), 32'h0);
        chk("s0_drain_instr", out_instr0, 32'h0);
        out_ready0 = 1'b0;
        // random valid/ready against a FIFO model of the skid stage
        next_pc = 32'h0000_4000;
        for (int c = 0; c < 3000; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            if (in_valid) drive(next_pc);
            else drive($urandom);
            #1;
            chk("rnd_rdy", 32'(in_ready1), 32'(q.size() != 2));
            acc = in_valid && q.size() != 2;
            con = out_ready && q.size() != 0;
            tick();
            if (con) void'(q.pop_front());
            if (acc) begin
                q.push_back(next_pc);
                next_pc = next_pc + 32'h4;
            end
            chk1("rnd", q.size() != 0, q.size() != 0 ? q[0] : 32'h0, 2'(q.size()));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
